microsequencer: RTL and testbench
=================================

# microsequencer

Control-unit next-address stage that produces the 7-bit microstore index every clock. Sits directly upstream of the microstore ROM and closes the loop with it: it takes the sequencing fields of the current microinstruction, the instruction decoder's entry address and status inputs, then registers the next index. Supports increment, jump, decode dispatch, conditional branch, wait-for-memory and a small microsubroutine stack.

## Interface
- `ADDR_W`, 7: microstore address width.
- `STACK_DEPTH`, 4: return-stack entries (power of two, 2..8).
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high.
- `stall`  in  1  hold all state (index, stack) this cycle.
- `ns`  in  3  next-state select field of current microinstruction.
- `cs`  in  3  condition select field.
- `inv`  in  1  invert selected condition.
- `cr_addr`  in  ADDR_W  target address field.
- `dec_addr`  in  ADDR_W  instruction-decoder entry address.
- `moc`  in  1  memory operation complete.
- `cond_ok`  in  1  ARM condition-code test result.
- `flags`  in  4  N,Z,C,V (bit 3 = N).
- `index`  out  ADDR_W  registered microstore address.
- `stk_err`  out  1  sticky stack over/underflow flag.

## Operation
- Condition mux `cs`: 000 moc, 001 cond_ok, 010 N, 011 Z, 100 C, 101 V, 110 constant 1, 111 constant 0. `c = sel ^ inv`.
- `incr = index + 1`, modulo 2^ADDR_W (127 wraps to 0).
- `ns` decode (next index):
  - 000 INC: incr.
  - 001 JMP: cr_addr.
  - 010 DEC: dec_addr.
  - 011 BR: c ? cr_addr : incr.
  - 100 CALL: push incr; next = cr_addr.
  - 101 RET: pop; next = popped value.
  - 110 WAIT: c ? incr : index (hold).
  - 111 FETCH: 0.
- Stack full on CALL: no push, still jumps to cr_addr, `stk_err` set. Stack empty on RET: next = 0, `stk_err` set.
- Priority: reset > stall > ns decode.
- `stk_err` clears only on reset.

## Timing
- Reset: `index` = 0, stack pointer = 0 (empty), `stk_err` = 0, effective next edge after `reset` sampled high; reset mid-WAIT or mid-subroutine discards all state.
- All inputs sampled on rising `clk`; `index` updates one cycle later; ROM output is combinational from `index`, so each microinstruction executes exactly one cycle.
- WAIT with `moc` low holds `index` indefinitely; `moc` high on edge N gives `index = incr` after edge N.
- `stall` high: `index`, stack contents, pointer and `stk_err` unchanged, regardless of `ns`.
- CALL and RET affect stack on the same edge as `index`; back-to-back CALL/RET is legal (push then pop returns same value).

## Configuration
- `MICROSEQ_STACK_EN` defined: CALL/RET and stack as above, `stk_err` live.
- Not defined: no stack storage; CALL behaves as JMP, RET behaves as FETCH (next = 0); `stk_err` tied 0.

## Structure
- Shared package: `ADDR_W`, `FETCH_ADDR = 0`, `ns` encodings (NS_INC, NS_JMP, NS_DEC, NS_BR, NS_CALL, NS_RET, NS_WAIT, NS_FETCH), `cs` encodings (CS_MOC, CS_COND, CS_N, CS_Z, CS_C, CS_V, CS_ONE, CS_ZERO).
- One sub-module: `micro_stack` (LIFO, push/pop/full/empty, `STACK_DEPTH` x `ADDR_W`), instantiated only under `MICROSEQ_STACK_EN`.

## Test plan
- Reset held 2 cycles with ns=JMP, cr_addr=0x55 -> `index`=0, `stk_err`=0; release with ns=INC -> 1, 2, 3.
- index=0x7F, ns=INC -> 0x00 (wrap); ns=DEC, dec_addr=0x28 -> 0x28.
- ns=BR, cs=Z, flags=0100, inv=0, cr_addr=0x10 from index 5 -> 0x10; inv=1 -> 6.
- ns=WAIT, cs=MOC, moc low 3 cycles then high, index 0x0A -> 0x0A x3 then 0x0B; stall high during WAIT with moc high -> still 0x0A.
- Stack: CALL 0x40 from 0x02, CALL 0x50 from 0x41, RET, RET -> 0x40, 0x50, 0x42, 0x03; five nested CALLs (depth 4) -> fifth jumps, `stk_err`=1; RET on empty -> 0, `stk_err`=1.
- Without `MICROSEQ_STACK_EN`: CALL cr_addr=0x30 -> 0x30; RET -> 0; `stk_err` stays 0.

Source files
------------

// File: rtl/microsequencer_pkg.sv
// Shared encodings for the microsequencer next-address stage.
// Sequencing field values, condition selects and the fetch entry point.
package microsequencer_pkg;

  localparam int ADDR_W     = 7;
  localparam int FETCH_ADDR = 0;

  typedef enum logic [2:0] {
    NS_INC   = 3'b000,
    NS_JMP   = 3'b001,
    NS_DEC   = 3'b010,
    NS_BR    = 3'b011,
    NS_CALL  = 3'b100,
    NS_RET   = 3'b101,
    NS_WAIT  = 3'b110,
    NS_FETCH = 3'b111
  } ns_e;

  typedef enum logic [2:0] {
    CS_MOC  = 3'b000,
    CS_COND = 3'b001,
    CS_N    = 3'b010,
    CS_Z    = 3'b011,
    CS_C    = 3'b100,
    CS_V    = 3'b101,
    CS_ONE  = 3'b110,
    CS_ZERO = 3'b111
  } cs_e;

  // flags are packed N,Z,C,V from bit 3 down to bit 0
  function automatic logic cond_sel(
    input logic [2:0] cs,
    input logic       moc,
    input logic       cond_ok,
    input logic [3:0] flags
  );
    logic r;
    r = 1'b0;
    case (cs)
      CS_MOC:  r = moc;
      CS_COND: r = cond_ok;
      CS_N:    r = flags[3];
      CS_Z:    r = flags[2];
      CS_C:    r = flags[1];
      CS_V:    r = flags[0];
      CS_ONE:  r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/microsequencer_stack.sv
// Microsubroutine return stack: small LIFO of return addresses.
// dout always shows the top entry; push on full and pop on empty are ignored.
module micro_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [AW-1:0]    top_idx;

  assign top_idx = ptr_q[AW-1:0] - AW'(1);
  assign dout    = mem_q[top_idx];
  assign full    = (ptr_q == PW'(DEPTH));
  assign empty   = (ptr_q == '0);

  always_comb begin
    mem_d = mem_q;
    ptr_d = ptr_q;
    if (push && !full) begin
      mem_d[ptr_q[AW-1:0]] = din;
      ptr_d = ptr_q + PW'(1);
    end else if (pop && !empty) begin
      ptr_d = ptr_q - PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  // contents need no reset: an empty pointer makes them unreachable
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/microsequencer.sv
// Next-address stage for the microstore: registers the 7-bit index each clock.
// MICROSEQ_STACK_EN enables CALL/RET via micro_stack and the sticky stk_err.
module microsequencer
  import microsequencer_pkg::*;
#(
  parameter int ADDR_W      = microsequencer_pkg::ADDR_W,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic [2:0]        ns,
  input  logic [2:0]        cs,
  input  logic              inv,
  input  logic [ADDR_W-1:0] cr_addr,
  input  logic [ADDR_W-1:0] dec_addr,
  input  logic              moc,
  input  logic              cond_ok,
  input  logic [3:0]        flags,
  output logic [ADDR_W-1:0] index,
  output logic              stk_err
);

  if (STACK_DEPTH < 2 || STACK_DEPTH > 8 ||
      (STACK_DEPTH & (STACK_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("STACK_DEPTH must be a power of two in 2..8");
  end

  logic [ADDR_W-1:0] index_q, index_d;
  logic [ADDR_W-1:0] incr;
  logic              c;

  assign incr  = index_q + ADDR_W'(1);
  assign c     = cond_sel(cs, moc, cond_ok, flags) ^ inv;
  assign index = index_q;

`ifdef MICROSEQ_STACK_EN
  logic              err_q, err_d;
  logic              push, pop, full, empty;
  logic [ADDR_W-1:0] pop_val;

  micro_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (ADDR_W)
  ) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (incr),
    .dout  (pop_val),
    .full  (full),
    .empty (empty)
  );

  assign stk_err = err_q;
`else
  assign stk_err = 1'b0;
`endif

  always_comb begin
    index_d = index_q;
`ifdef MICROSEQ_STACK_EN
    err_d = err_q;
    push  = 1'b0;
    pop   = 1'b0;
`endif
    if (!stall) begin
      case (ns)
        NS_INC:  index_d = incr;
        NS_JMP:  index_d = cr_addr;
        NS_DEC:  index_d = dec_addr;
        NS_BR:   index_d = c ? cr_addr : incr;
        NS_WAIT: index_d = c ? incr : index_q;
`ifdef MICROSEQ_STACK_EN
        NS_CALL: begin
          index_d = cr_addr;
          if (full) err_d = 1'b1;
          else      push  = 1'b1;
        end
        NS_RET: begin
          if (empty) begin
            index_d = ADDR_W'(FETCH_ADDR);
            err_d   = 1'b1;
          end else begin
            index_d = pop_val;
            pop     = 1'b1;
          end
        end
`else
        NS_CALL: index_d = cr_addr;
        NS_RET:  index_d = ADDR_W'(FETCH_ADDR);
`endif
        default: index_d = ADDR_W'(FETCH_ADDR);
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      index_q <= ADDR_W'(FETCH_ADDR);
`ifdef MICROSEQ_STACK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      index_q <= index_d;
`ifdef MICROSEQ_STACK_EN
      err_q   <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_microsequencer.sv
// Scoreboard bench for microsequencer: directed steps push expected index/stk_err,
// a monitor pops and compares one entry after every rising edge.
module tb_microsequencer;

  localparam logic [2:0] INC = 3'b000, JMP = 3'b001, DEC = 3'b010, BR = 3'b011;
  localparam logic [2:0] CALL = 3'b100, RET = 3'b101, WAITS = 3'b110, FETCH = 3'b111;
  localparam logic [2:0] C_MOC = 3'b000, C_COND = 3'b001, C_N = 3'b010, C_Z = 3'b011;
  localparam logic [2:0] C_C = 3'b100, C_V = 3'b101, C_ONE = 3'b110, C_ZERO = 3'b111;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       stall = 1'b0;
  logic [2:0] ns = JMP;
  logic [2:0] cs = C_ZERO;
  logic       inv = 1'b0;
  logic [6:0] cr_addr = 7'h00;
  logic [6:0] dec_addr = 7'h00;
  logic       moc = 1'b0;
  logic       cond_ok = 1'b0;
  logic [3:0] flags = 4'h0;
  logic [6:0] index;
  logic       stk_err;

  typedef struct {
    logic [6:0] idx;
    logic       err;
    int         tag;
  } exp_t;

  exp_t sb[$];
  int   tag = 0;
  int   checks = 0;
  int   fails = 0;

  microsequencer dut (
    .clk      (clk),
    .reset    (reset),
    .stall    (stall),
    .ns       (ns),
    .cs       (cs),
    .inv      (inv),
    .cr_addr  (cr_addr),
    .dec_addr (dec_addr),
    .moc      (moc),
    .cond_ok  (cond_ok),
    .flags    (flags),
    .index    (index),
    .stk_err  (stk_err)
  );

  always #5 clk = ~clk;

  task automatic step(input logic [2:0] n, input logic [6:0] cr,
                      input logic [6:0] ei, input logic ee);
    ns      = n;
    cr_addr = cr;
    sb.push_back('{idx: ei, err: ee, tag: tag});
    tag++;
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (index !== e.idx) begin
          fails++;
          $display("FAIL index step %0d: got %h expected %h", e.tag, index, e.idx);
        end
        checks++;
        if (stk_err !== e.err) begin
          fails++;
          $display("FAIL stk_err step %0d: got %b expected %b", e.tag, stk_err, e.err);
        end
      end
    end
  end

  initial begin : driver
    int n;
    @(negedge clk);
    reset = 1'b1;
    step(JMP, 7'h55, 7'h00, 1'b0);
    step(JMP, 7'h55, 7'h00, 1'b0);
    reset = 1'b0;
    step(INC, 7'h00, 7'h01, 1'b0);
    step(INC, 7'h00, 7'h02, 1'b0);
    step(INC, 7'h00, 7'h03, 1'b0);
    step(JMP, 7'h7F, 7'h7F, 1'b0);
    step(INC, 7'h00, 7'h00, 1'b0);
    dec_addr = 7'h28;
    step(DEC, 7'h00, 7'h28, 1'b0);
    step(JMP, 7'h05, 7'h05, 1'b0);
    cs = C_Z; flags = 4'b0100; inv = 1'b0;
    step(BR, 7'h10, 7'h10, 1'b0);
    step(JMP, 7'h05, 7'h05, 1'b0);
    inv = 1'b1;
    step(BR, 7'h10, 7'h06, 1'b0);
    inv = 1'b0;
    step(JMP, 7'h0A, 7'h0A, 1'b0);
    cs = C_MOC; moc = 1'b0;
    for (int i = 0; i < 3; i++) step(WAITS, 7'h00, 7'h0A, 1'b0);
    moc = 1'b1; stall = 1'b1;
    step(WAITS, 7'h00, 7'h0A, 1'b0);
    stall = 1'b0;
    step(WAITS, 7'h00, 7'h0B, 1'b0);
    moc = 1'b0;
    cs = C_ONE;
    step(BR, 7'h20, 7'h20, 1'b0);
    cs = C_ZERO;
    step(BR, 7'h20, 7'h21, 1'b0);
    cs = C_N; flags = 4'b1000;
    step(BR, 7'h30, 7'h30, 1'b0);
    cs = C_C;
    step(BR, 7'h50, 7'h31, 1'b0);
    cs = C_V; flags = 4'b0001;
    step(BR, 7'h50, 7'h50, 1'b0);
    cs = C_COND; cond_ok = 1'b1; inv = 1'b1;
    step(BR, 7'h10, 7'h51, 1'b0);
    inv = 1'b0;
    step(FETCH, 7'h22, 7'h00, 1'b0);
    stall = 1'b1;
    step(JMP, 7'h11, 7'h00, 1'b0);
    stall = 1'b0;
`ifdef MICROSEQ_STACK_EN
    step(JMP, 7'h02, 7'h02, 1'b0);
    step(CALL, 7'h40, 7'h40, 1'b0);
    step(INC, 7'h00, 7'h41, 1'b0);
    step(CALL, 7'h50, 7'h50, 1'b0);
    step(RET, 7'h00, 7'h42, 1'b0);
    step(RET, 7'h00, 7'h03, 1'b0);
    step(CALL, 7'h10, 7'h10, 1'b0);
    step(CALL, 7'h20, 7'h20, 1'b0);
    step(CALL, 7'h30, 7'h30, 1'b0);
    step(CALL, 7'h40, 7'h40, 1'b0);
    step(CALL, 7'h60, 7'h60, 1'b1);
    stall = 1'b1;
    step(RET, 7'h00, 7'h60, 1'b1);
    stall = 1'b0;
    step(RET, 7'h00, 7'h31, 1'b1);
    step(RET, 7'h00, 7'h21, 1'b1);
    step(RET, 7'h00, 7'h11, 1'b1);
    step(RET, 7'h00, 7'h04, 1'b1);
    step(RET, 7'h00, 7'h00, 1'b1);
    step(CALL, 7'h33, 7'h33, 1'b1);
    reset = 1'b1;
    step(JMP, 7'h55, 7'h00, 1'b0);
    reset = 1'b0;
    step(CALL, 7'h70, 7'h70, 1'b0);
    step(RET, 7'h00, 7'h01, 1'b0);
    step(RET, 7'h00, 7'h00, 1'b1);
`else
    step(JMP, 7'h02, 7'h02, 1'b0);
    step(CALL, 7'h30, 7'h30, 1'b0);
    step(RET, 7'h00, 7'h00, 1'b0);
    step(CALL, 7'h45, 7'h45, 1'b0);
    step(INC, 7'h00, 7'h46, 1'b0);
    step(RET, 7'h00, 7'h00, 1'b0);
    step(RET, 7'h00, 7'h00, 1'b0);
`endif
    ns = INC;
    n = 0;
    while (sb.size() > 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
